// File: rtl/riscv_pkg.sv
// Shared datapath constants for the RISC-V core blocks and their unit benches.
// Holds the machine word width and the defaults used by the selector and clock source.
package riscv_pkg;

    localparam int          XLEN                = 32;
    localparam logic [31:0] DEF_RESET_VALUE     = 32'h0000_0000;
    localparam int          DEF_CLK_HALF_PERIOD = 5;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/mux2_sel_unit_if.sv
// Signal bundle for the 2:1 word selector: data/select toward the block,
// combinational and registered results back out.
interface mux2_sel_unit_if
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             selection;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic             sel_changed;

    modport master (
        output A, B, selection,
        input  out, out_q, sel_q, sel_changed
    );

    modport slave (
        input  A, B, selection,
        output out, out_q, sel_q, sel_changed
    );

endinterface

// File: rtl/mux2_sel_unit.sv
// Word-wide 2:1 selector for operand / PC-source / writeback selection.
// Gives a zero-latency result plus a registered copy and a select-change pulse.
module mux2_sel_unit
    import riscv_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             selection,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic             sel_changed
);

    logic [WIDTH-1:0] out_d;
    logic             sel_d;
    logic             sel_changed_d;
    logic             sel_changed_q;

    // Plain ternary so an unknown select merges A/B bitwise instead of defaulting to A.
    assign out = selection ? B : A;

    always_comb begin
        out_d         = out;
        sel_d         = selection;
        sel_changed_d = (selection != sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= RESET_VALUE;
            sel_q         <= 1'b0;
            sel_changed_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            sel_q         <= sel_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_mux2_sel_unit.sv
// Unit bench for mux2_sel_unit, including the shared free-running clock source.
// Stimulus side pushes predicted registered results; a monitor pops them each edge.
module sim_clock_source #(
    parameter int CLK_HALF_PERIOD = riscv_pkg::DEF_CLK_HALF_PERIOD
) (
    output logic clk
);
    initial begin
        clk = 1'b0;
        forever #(CLK_HALF_PERIOD) clk = ~clk;
    end
endmodule

module tb_mux2_sel_unit;
    import riscv_pkg::*;

    localparam int HP = 5;

    typedef struct {
        logic [31:0] oq;
        logic        s;
        logic        c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t sb[$];
    logic prev_sel;

    mux2_sel_unit_if #(.WIDTH(32)) ifc ();

    sim_clock_source #(.CLK_HALF_PERIOD(HP)) u_clk (.clk(clk));

    mux2_sel_unit #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (ifc.A),
        .B          (ifc.B),
        .selection  (ifc.selection),
        .out        (ifc.out),
        .out_q      (ifc.out_q),
        .sel_q      (ifc.sel_q),
        .sel_changed(ifc.sel_changed)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs away from the edge and predict the next edge's registers.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        @(negedge clk);
        ifc.A = a; ifc.B = b; ifc.selection = s;
        #1;
        chk("out_comb", 64'(ifc.out), 64'(s ? b : a));
        e.oq = s ? b : a;
        e.s  = s;
        e.c  = (s != prev_sel);
        sb.push_back(e);
        prev_sel = s;
    endtask

    // Monitor: every edge with work outstanding, compare registered outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_q",       64'(ifc.out_q),       64'(e.oq));
            chk("sel_q",       64'(ifc.sel_q),       64'(e.s));
            chk("sel_changed", 64'(ifc.sel_changed), 64'(e.c));
        end
    end

    // Clock source timing.
    initial begin
        time t1, t2, t3, tf;
        #1;
        chk("clk_t0", 64'(clk), 64'(1'b0));
        @(posedge clk); t1 = $time;
        @(posedge clk); t2 = $time;
        @(posedge clk); t3 = $time;
        @(negedge clk); tf = $time;
        chk("clk_rise1", 64'(t1), 64'(HP));
        chk("clk_rise2", 64'(t2), 64'(3 * HP));
        chk("clk_rise3", 64'(t3), 64'(5 * HP));
        chk("clk_period", 64'(t3 - t2), 64'(2 * HP));
        chk("clk_high", 64'(tf - t3), 64'(HP));
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst_n = 1'b0;
        ifc.A = '0; ifc.B = '0; ifc.selection = 1'b0;
        prev_sel = 1'b0;
        #2;
        chk("rst_out_q", 64'(ifc.out_q), 64'(0));
        chk("rst_sel_q", 64'(ifc.sel_q), 64'(0));
        chk("rst_chg",   64'(ifc.sel_changed), 64'(0));
        chk("rst_out",   64'(ifc.out), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        drive(32'h0, 32'h1234_5678, 1'b0);
        drive(32'h0, 32'h1234_5678, 1'b1);
        drive(32'h0, 32'h8765_4321, 1'b0);
        drive(32'h0, 32'h8765_4321, 1'b1);
        drive(32'h1111_2222, 32'h0, 1'b0);
        drive(32'h1111_2222, 32'h0, 1'b1);
        drive(32'h1111_2222, 32'h0, 1'b0);
        repeat (3) drive(32'hDEAD_BEEF, 32'h5555_AAAA, 1'b0);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            s = 1'($urandom_range(0, 1));
            drive(a, b, s);
        end

        // Asynchronous reset mid-cycle with a nonzero registered value.
        drive(32'h0, 32'h8765_4321, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", 64'(ifc.out_q), 64'(0));
        chk("arst_sel_q", 64'(ifc.sel_q), 64'(0));
        chk("arst_chg",   64'(ifc.sel_changed), 64'(0));
        chk("arst_out",   64'(ifc.out), 64'(32'h8765_4321));
        ifc.A = 32'hCAFE_F00D; ifc.selection = 1'b0;
        #1;
        chk("arst_out_live", 64'(ifc.out), 64'(32'hCAFE_F00D));
        @(posedge clk); #1;
        chk("arst_hold_q", 64'(ifc.out_q), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        prev_sel = 1'b0;

        // First edge after release compares against the reset value of sel_q.
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
